// File: rtl/mpc_response_rx.sv
// mpc_response_rx
//
// Captures the MPC accept response that follows each LCT frame sent to the MPC.
// A delay pipeline carries each transmit strobe (and which LCTs it carried) for
// a programmable number of bx. When the strobe reaches the selected tap, the
// demultiplexed response bits are latched. Accept bits that name an LCT which
// was not in the frame raise rsp_err. Saturating counters are kept for VME readout.
//
// Ports:
//   clock         40 MHz system clock
//   reset_n       asynchronous active-low reset
//   mpc_rx_en     enables response sampling and stray detection
//   mpc_delay     bx from transmit to response sample (0 behaves as 1)
//   din1st        accept bits [1:0] (first-in-time demux slice)
//   din2nd        reserved bits [1:0] (second-in-time demux slice)
//   xmit_strobe   one-cycle pulse, frame sent this bx
//   xmit_lct      LCTs carried by the frame (bit0 = 1st, bit1 = 2nd)
//   cnt_clear     synchronous clear of all counters
//   rsp_valid     one-cycle pulse, response latched
//   rsp_accept    latched accept bits, held until next rsp_valid
//   rsp_reserved  latched reserved bits, held until next rsp_valid
//   rsp_err       one-cycle pulse, accept for an LCT not sent
//   cnt_xmit      transmitted frames
//   cnt_accept    accepted LCTs
//   cnt_err       rsp_err events
//   cnt_stray     nonzero accept bits outside any window
module mpc_response_rx #(
   parameter int unsigned WIDTH_CNT = 16,
   parameter int unsigned MAX_DELAY = 15
) (
   input  logic                 clock,
   input  logic                 reset_n,
   input  logic                 mpc_rx_en,
   input  logic [3:0]           mpc_delay,
   input  logic [1:0]           din1st,
   input  logic [1:0]           din2nd,
   input  logic                 xmit_strobe,
   input  logic [1:0]           xmit_lct,
   input  logic                 cnt_clear,
   output logic                 rsp_valid,
   output logic [1:0]           rsp_accept,
   output logic [1:0]           rsp_reserved,
   output logic                 rsp_err,
   output logic [WIDTH_CNT-1:0] cnt_xmit,
   output logic [WIDTH_CNT-1:0] cnt_accept,
   output logic [WIDTH_CNT-1:0] cnt_err,
   output logic [WIDTH_CNT-1:0] cnt_stray
);

   // Delay pipeline: strobe and LCT mask side by side
   logic [MAX_DELAY-1:0] sr_strobe;
   logic [1:0]           sr_lct [MAX_DELAY];

   logic       tap_strobe;
   logic [1:0] tap_lct;
   logic       hit;
   logic       err_cond;
   logic       stray_cond;
   logic [1:0] accept_pop;
   logic [1:0] accepted;
   int         tap_idx;

   // Saturating add of a 0..3 increment
   function automatic logic [WIDTH_CNT-1:0] sat_add(input logic [WIDTH_CNT-1:0] a,
                                                     input logic [1:0]           inc);
      logic [WIDTH_CNT:0] sum;
      sum = {1'b0, a} + {{(WIDTH_CNT - 1){1'b0}}, inc};
      return sum[WIDTH_CNT] ? '1 : sum[WIDTH_CNT-1:0];
   endfunction

   // Tap select: delay 0 acts as 1; delays beyond the pipeline clamp to its end
   always_comb begin
      tap_idx = (mpc_delay == 4'd0) ? 0 : int'(mpc_delay) - 1;
      if (tap_idx > int'(MAX_DELAY) - 1) begin
         tap_idx = int'(MAX_DELAY) - 1;
      end
      tap_strobe = 1'b0;
      tap_lct    = 2'b00;
      for (int k = 0; k < int'(MAX_DELAY); k++) begin
         if (k == tap_idx) begin
            tap_strobe = sr_strobe[k];
            tap_lct    = sr_lct[k];
         end
      end
   end

   always_comb begin
      hit        = tap_strobe & mpc_rx_en;
      err_cond   = |(din1st & ~tap_lct);
      accepted   = din1st & tap_lct;
      accept_pop = {1'b0, accepted[0]} + {1'b0, accepted[1]};
      stray_cond = ~hit & mpc_rx_en & (din1st != 2'b00);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sr_strobe <= '0;
         for (int k = 0; k < int'(MAX_DELAY); k++) begin
            sr_lct[k] <= 2'b00;
         end
      end else begin
         sr_strobe <= {sr_strobe[MAX_DELAY-2:0], xmit_strobe};
         sr_lct[0] <= xmit_lct;
         for (int k = 1; k < int'(MAX_DELAY); k++) begin
            sr_lct[k] <= sr_lct[k-1];
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rsp_valid    <= 1'b0;
         rsp_accept   <= 2'b00;
         rsp_reserved <= 2'b00;
         rsp_err      <= 1'b0;
      end else begin
         rsp_valid <= hit;
         rsp_err   <= hit & err_cond;
         if (hit) begin
            rsp_accept   <= din1st;
            rsp_reserved <= din2nd;
         end
      end
   end

   // Clear wins over any same-cycle increment
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cnt_xmit   <= '0;
         cnt_accept <= '0;
         cnt_err    <= '0;
         cnt_stray  <= '0;
      end else if (cnt_clear) begin
         cnt_xmit   <= '0;
         cnt_accept <= '0;
         cnt_err    <= '0;
         cnt_stray  <= '0;
      end else begin
         if (xmit_strobe) begin
            cnt_xmit <= sat_add(cnt_xmit, 2'd1);
         end
         if (hit) begin
            cnt_accept <= sat_add(cnt_accept, accept_pop);
         end
         if (hit && err_cond) begin
            cnt_err <= sat_add(cnt_err, 2'd1);
         end
         if (stray_cond) begin
            cnt_stray <= sat_add(cnt_stray, 2'd1);
         end
      end
   end

endmodule

// File: tb/tb_mpc_response_rx.sv
// Testbench for mpc_response_rx: per-cycle vector table plus hand-written
// sequences for maximum delay, mid-flight reset and counter saturation.
module tb_mpc_response_rx;

   typedef struct packed {
      logic       en;
      logic [3:0] dly;
      logic [1:0] d1;
      logic [1:0] d2;
      logic       stb;
      logic [1:0] lct;
      logic       clr;
   } in_t;

   typedef struct packed {
      logic        v;
      logic [1:0]  a;
      logic [1:0]  r;
      logic        e;
      logic [15:0] x;
      logic [15:0] ac;
      logic [15:0] er;
      logic [15:0] st;
   } exp_t;

   typedef struct packed {
      in_t  in;
      exp_t ex;
   } vec_t;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        mpc_rx_en;
   logic [3:0]  mpc_delay;
   logic [1:0]  din1st;
   logic [1:0]  din2nd;
   logic        xmit_strobe;
   logic [1:0]  xmit_lct;
   logic        cnt_clear;
   logic        rsp_valid;
   logic [1:0]  rsp_accept;
   logic [1:0]  rsp_reserved;
   logic        rsp_err;
   logic [15:0] cnt_xmit;
   logic [15:0] cnt_accept;
   logic [15:0] cnt_err;
   logic [15:0] cnt_stray;

   int n_vec  = 0;
   int n_miss = 0;
   vec_t tbl[$];

   mpc_response_rx #(
      .WIDTH_CNT(16),
      .MAX_DELAY(15)
   ) dut (
      .clock        (clock),
      .reset_n      (reset_n),
      .mpc_rx_en    (mpc_rx_en),
      .mpc_delay    (mpc_delay),
      .din1st       (din1st),
      .din2nd       (din2nd),
      .xmit_strobe  (xmit_strobe),
      .xmit_lct     (xmit_lct),
      .cnt_clear    (cnt_clear),
      .rsp_valid    (rsp_valid),
      .rsp_accept   (rsp_accept),
      .rsp_reserved (rsp_reserved),
      .rsp_err      (rsp_err),
      .cnt_xmit     (cnt_xmit),
      .cnt_accept   (cnt_accept),
      .cnt_err      (cnt_err),
      .cnt_stray    (cnt_stray)
   );

   always #5 clock = ~clock;

   function automatic vec_t mk(input logic en, input logic [3:0] dly, input logic [1:0] d1,
                               input logic [1:0] d2, input logic stb, input logic [1:0] lct,
                               input logic clr, input logic v, input logic [1:0] a,
                               input logic [1:0] r, input logic e, input logic [15:0] x,
                               input logic [15:0] ac, input logic [15:0] er,
                               input logic [15:0] st);
      vec_t t;
      t.in = '{en: en, dly: dly, d1: d1, d2: d2, stb: stb, lct: lct, clr: clr};
      t.ex = '{v: v, a: a, r: r, e: e, x: x, ac: ac, er: er, st: st};
      return t;
   endfunction

   task automatic drive(input in_t i);
      mpc_rx_en   = i.en;
      mpc_delay   = i.dly;
      din1st      = i.d1;
      din2nd      = i.d2;
      xmit_strobe = i.stb;
      xmit_lct    = i.lct;
      cnt_clear   = i.clr;
   endtask

   task automatic check(input string name, input exp_t want);
      exp_t got;
      got = '{v: rsp_valid, a: rsp_accept, r: rsp_reserved, e: rsp_err, x: cnt_xmit,
              ac: cnt_accept, er: cnt_err, st: cnt_stray};
      n_vec++;
      if (got !== want) begin
         n_miss++;
         $display("FAIL %s: got v=%b acc=%b res=%b err=%b xmit=%h acc_cnt=%h err_cnt=%h stray=%h ; want v=%b acc=%b res=%b err=%b xmit=%h acc_cnt=%h err_cnt=%h stray=%h",
                  name, got.v, got.a, got.r, got.e, got.x, got.ac, got.er, got.st,
                  want.v, want.a, want.r, want.e, want.x, want.ac, want.er, want.st);
      end
   endtask

   task automatic check_xmit(input string name, input logic [15:0] want);
      n_vec++;
      if (cnt_xmit !== want) begin
         n_miss++;
         $display("FAIL %s: cnt_xmit got %h want %h", name, cnt_xmit, want);
      end
   endtask

   // Apply inputs, clock once, compare 1 time unit after the edge
   task automatic step(input string name, input vec_t t);
      drive(t.in);
      @(posedge clock);
      #1;
      check(name, t.ex);
   endtask

   task automatic idle_cycles(input int n, input logic en, input logic [3:0] dly);
      in_t i;
      i = '{en: en, dly: dly, d1: 2'b00, d2: 2'b00, stb: 1'b0, lct: 2'b00, clr: 1'b0};
      drive(i);
      repeat (n) @(posedge clock);
      #1;
   endtask

   initial begin
      reset_n = 1'b0;
      drive('0);
      repeat (3) @(posedge clock);
      #1;
      check("reset", '0);
      reset_n = 1'b1;

      // Basic window at delay 3
      tbl.push_back(mk(1, 3, 0, 0, 1, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      tbl.push_back(mk(1, 3, 1, 2, 0, 0, 0, 1, 1, 2, 0, 1, 1, 0, 0));
      tbl.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0, 1, 2, 0, 1, 1, 0, 0));
      // Delay 0 acts as 1; accept for unsent 2nd LCT
      tbl.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 1, 2, 0, 2, 1, 0, 0));
      tbl.push_back(mk(1, 0, 2, 0, 0, 0, 0, 1, 2, 0, 1, 2, 1, 1, 0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 2, 1, 1, 0));
      // Stray with and without enable
      tbl.push_back(mk(1, 0, 3, 0, 0, 0, 0, 0, 2, 0, 0, 2, 1, 1, 1));
      tbl.push_back(mk(0, 0, 3, 0, 0, 0, 0, 0, 2, 0, 0, 2, 1, 1, 1));
      // Pending strobe while disabled produces nothing but cnt_xmit
      tbl.push_back(mk(0, 1, 0, 0, 1, 3, 0, 0, 2, 0, 0, 3, 1, 1, 1));
      tbl.push_back(mk(0, 1, 3, 0, 0, 0, 0, 0, 2, 0, 0, 3, 1, 1, 1));
      tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 2, 0, 0, 3, 1, 1, 1));
      // Back-to-back at delay 2 with different LCT masks
      tbl.push_back(mk(1, 2, 0, 0, 1, 1, 0, 0, 2, 0, 0, 4, 1, 1, 1));
      tbl.push_back(mk(1, 2, 0, 0, 1, 2, 0, 0, 2, 0, 0, 5, 1, 1, 1));
      tbl.push_back(mk(1, 2, 3, 1, 0, 0, 0, 1, 3, 1, 1, 5, 2, 2, 1));
      tbl.push_back(mk(1, 2, 1, 0, 0, 0, 0, 1, 1, 0, 1, 5, 2, 3, 1));
      tbl.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0, 1, 0, 0, 5, 2, 3, 1));
      // Clear beats a same-cycle stray increment
      tbl.push_back(mk(1, 2, 3, 0, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0));
      tbl.push_back(mk(1, 2, 3, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));

      foreach (tbl[i]) begin
         step($sformatf("vec[%0d]", i), tbl[i]);
      end

      // Drain the pipeline before the deep-delay test
      idle_cycles(16, 1'b0, 4'd15);

      // Back-to-back strobes at maximum delay
      step("d15_stb0", mk(1, 15, 0, 0, 1, 3, 0, 0, 1, 0, 0, 1, 0, 0, 1));
      step("d15_stb1", mk(1, 15, 0, 0, 1, 3, 0, 0, 1, 0, 0, 2, 0, 0, 1));
      for (int i = 0; i < 13; i++) begin
         step($sformatf("d15_wait%0d", i), mk(1, 15, 0, 0, 0, 0, 0, 0, 1, 0, 0, 2, 0, 0, 1));
      end
      step("d15_hit0", mk(1, 15, 3, 0, 0, 0, 0, 1, 3, 0, 0, 2, 2, 0, 1));
      step("d15_hit1", mk(1, 15, 3, 0, 0, 0, 0, 1, 3, 0, 0, 2, 4, 0, 1));
      step("d15_after", mk(1, 15, 0, 0, 0, 0, 0, 0, 3, 0, 0, 2, 4, 0, 1));

      // Reset while a strobe is in flight at delay 5
      step("rst_stb", mk(1, 5, 0, 0, 1, 3, 0, 0, 3, 0, 0, 3, 4, 0, 1));
      step("rst_idle", mk(1, 5, 0, 0, 0, 0, 0, 0, 3, 0, 0, 3, 4, 0, 1));
      reset_n = 1'b0;
      #1;
      check("rst_async", '0);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step($sformatf("rst_post%0d", i), mk(1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      end

      // Saturation of cnt_xmit, then clear with a same-cycle strobe
      drive('{en: 1'b0, dly: 4'd1, d1: 2'b00, d2: 2'b00, stb: 1'b1, lct: 2'b01, clr: 1'b0});
      repeat (65540) @(posedge clock);
      #1;
      check_xmit("sat", 16'hFFFF);
      cnt_clear = 1'b1;
      @(posedge clock);
      #1;
      check_xmit("clr_with_stb", 16'h0000);
      cnt_clear = 1'b0;
      @(posedge clock);
      #1;
      check_xmit("after_clr", 16'h0001);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
